// File: rtl/hippo_score_pkg.sv
// Shared types and constants for the trial score recorder.
package hippo_score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DONE   = 2'd2,
    ST_DUMP   = 2'd3
  } state_t;

  localparam int DEF_N_TRIAL = 100;
  localparam int DEF_PHASES  = 2;
  localparam int DEF_WIN     = 10;
  localparam int DEF_CRIT    = 8;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n entries (0..n-1), never less than one.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/score_window.sv
// Sliding-window score over the last WIN recorded trials, plus the sticky
// learning criterion. WIN must be at least 2.
module score_window
  import hippo_score_pkg::*;
#(
  parameter int WIN   = DEF_WIN,
  parameter int CRIT  = DEF_CRIT,
  parameter int CNT_W = cnt_width(DEF_N_TRIAL),
  localparam int WC_W = cnt_width(WIN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] trials_rec,
  output logic [WC_W-1:0]  win_count,
  output logic             criterion_met,
  output logic [CNT_W-1:0] crit_trial
);

  logic [WIN-1:0] win_sr;

  // Shift the new trial in; the count tracks the bit entering and the one leaving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_sr    <= '0;
      win_count <= '0;
    end else if (clear) begin
      win_sr    <= '0;
      win_count <= '0;
    end else if (shift_en) begin
      win_sr    <= {win_sr[WIN-2:0], bit_in};
      win_count <= win_count + WC_W'(bit_in) - WC_W'(win_sr[WIN-1]);
    end
  end

  // Criterion looks at the registered count, so it lands one cycle after the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      criterion_met <= 1'b0;
      crit_trial    <= '0;
    end else if (clear) begin
      criterion_met <= 1'b0;
      crit_trial    <= '0;
    end else if (!criterion_met && (win_count >= WC_W'(CRIT))) begin
      criterion_met <= 1'b1;
      crit_trial    <= trials_rec;
    end
  end

endmodule

// File: rtl/trial_score_recorder.sv
// Records one rewarded/not bit per trial, keeps totals and a window score,
// then streams the stored bits out over valid/ready.
// Optional feature macro: SCORE_BLOCK_AVG_EN adds blk_valid/blk_count, a
// per-block (non-overlapping, WIN trials) reward count.
module trial_score_recorder
  import hippo_score_pkg::*;
#(
  parameter int N_TRIAL = DEF_N_TRIAL,
  parameter int PHASES  = DEF_PHASES,
  parameter int WIN     = DEF_WIN,
  parameter int CRIT    = DEF_CRIT,
  localparam int CNT_W  = cnt_width(N_TRIAL),
  localparam int WC_W   = cnt_width(WIN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             trial_done,
  input  logic             rewarded,
  output logic [CNT_W-1:0] trials_rec,
  output logic [CNT_W-1:0] total_correct,
  output logic [WC_W-1:0]  win_count,
  output logic             criterion_met,
  output logic [CNT_W-1:0] crit_trial,
  output logic             full,
  input  logic             dump_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_last
`ifdef SCORE_BLOCK_AVG_EN
  ,
  output logic             blk_valid,
  output logic [WC_W-1:0]  blk_count
`endif
);

  localparam int PH_W  = idx_width(PHASES);
  localparam int IDX_W = idx_width(N_TRIAL);

  state_t           state, state_nxt;
  logic [PH_W-1:0]  phase;
  logic [IDX_W-1:0] ptr;
  logic             mem [N_TRIAL];
  logic             phase_adv, rec_fire, last_trial, hs;

  assign phase_adv  = run && (state == ST_RECORD) && trial_done;
  assign rec_fire   = phase_adv && (phase == PH_W'(PHASES - 1));
  assign last_trial = (trials_rec == CNT_W'(N_TRIAL - 1));
  assign out_valid  = (state == ST_DUMP);
  assign out_data   = mem[ptr];
  assign out_last   = out_valid && (ptr == IDX_W'(N_TRIAL - 1));
  assign hs         = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state; dropping run overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_RECORD;
      ST_RECORD: if (rec_fire && last_trial) state_nxt = ST_DONE;
      ST_DONE:   if (dump_req) state_nxt = ST_DUMP;
      ST_DUMP:   if (hs && out_last) state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (!run) state_nxt = ST_IDLE;
  end

  // Phase counter, trial counters, score memory and readout pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase         <= '0;
      trials_rec    <= '0;
      total_correct <= '0;
      full          <= 1'b0;
      ptr           <= '0;
      for (int i = 0; i < N_TRIAL; i++) mem[i] <= 1'b0;
    end else if (!run) begin
      phase         <= '0;
      trials_rec    <= '0;
      total_correct <= '0;
      full          <= 1'b0;
      ptr           <= '0;
    end else begin
      if (phase_adv) phase <= rec_fire ? '0 : phase + 1'b1;
      if (rec_fire) begin
        mem[trials_rec[IDX_W-1:0]] <= rewarded;
        trials_rec    <= trials_rec + 1'b1;
        total_correct <= total_correct + CNT_W'(rewarded);
        if (last_trial) full <= 1'b1;
      end
      if ((state == ST_DONE) && dump_req) ptr <= '0;
      else if (hs)                        ptr <= out_last ? '0 : ptr + 1'b1;
    end
  end

  score_window #(
    .WIN   (WIN),
    .CRIT  (CRIT),
    .CNT_W (CNT_W)
  ) u_score_window (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (~run),
    .shift_en      (rec_fire),
    .bit_in        (rewarded),
    .trials_rec    (trials_rec),
    .win_count     (win_count),
    .criterion_met (criterion_met),
    .crit_trial    (crit_trial)
  );

`ifdef SCORE_BLOCK_AVG_EN
  logic [WC_W-1:0] blk_acc, blk_fill;

  // Block accumulator; the final trial flushes a partial block as DONE is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_acc   <= '0;
      blk_fill  <= '0;
      blk_valid <= 1'b0;
      blk_count <= '0;
    end else if (!run) begin
      blk_acc   <= '0;
      blk_fill  <= '0;
      blk_valid <= 1'b0;
      blk_count <= '0;
    end else begin
      blk_valid <= 1'b0;
      if (rec_fire) begin
        if ((blk_fill == WC_W'(WIN - 1)) || last_trial) begin
          blk_valid <= 1'b1;
          blk_count <= blk_acc + WC_W'(rewarded);
          blk_acc   <= '0;
          blk_fill  <= '0;
        end else begin
          blk_acc   <= blk_acc + WC_W'(rewarded);
          blk_fill  <= blk_fill + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_trial_score_recorder.sv
// Self-checking bench for trial_score_recorder (default parameters).
module tb_trial_score_recorder;
  import hippo_score_pkg::*;

  localparam int N  = 100;
  localparam int PH = 2;
  localparam int W  = 10;
  localparam int CR = 8;
  localparam int CW = cnt_width(N);
  localparam int WW = cnt_width(W);

  localparam int M_IDLE = 0;
  localparam int M_REC  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, trial_done = 1'b0, rewarded = 1'b0;
  logic dump_req = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] trials_rec, total_correct, crit_trial;
  logic [WW-1:0] win_count;
  logic criterion_met, full, out_valid, out_data, out_last;
`ifdef SCORE_BLOCK_AVG_EN
  logic blk_valid;
  logic [WW-1:0] blk_count;
  int blk_pulses = 0;
  int blk_last = 0;
`endif

  int checks = 0;
  int errors = 0;

  bit m_q[$];
  int m_phase, m_mode, m_crit_t;
  bit m_crit;

  trial_score_recorder dut (
    .clk(clk), .reset_n(reset_n), .run(run), .trial_done(trial_done), .rewarded(rewarded),
    .trials_rec(trials_rec), .total_correct(total_correct), .win_count(win_count),
    .criterion_met(criterion_met), .crit_trial(crit_trial), .full(full),
    .dump_req(dump_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
`ifdef SCORE_BLOCK_AVG_EN
    , .blk_valid(blk_valid), .blk_count(blk_count)
`endif
  );

  always #5 clk = ~clk;

`ifdef SCORE_BLOCK_AVG_EN
  always @(negedge clk) if (blk_valid) begin
    blk_pulses++;
    blk_last = blk_count;
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit td, input bit rw);
    run = r; trial_done = td; rewarded = rw;
    @(posedge clk); #1;
    trial_done = 1'b0;
  endtask

  function automatic int sum_last(input int k);
    int s = 0;
    int n = m_q.size();
    for (int i = (n > k ? n - k : 0); i < n; i++) s += m_q[i];
    return s;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_mode = M_IDLE; m_crit = 0; m_crit_t = 0;
  endtask

  // Reference: list of recorded bits; everything else derived from it.
  task automatic model_step(input bit r, input bit td, input bit rw);
    if (!r) model_reset();
    else begin
      if (!m_crit && sum_last(W) >= CR) begin
        m_crit = 1; m_crit_t = m_q.size();
      end
      case (m_mode)
        M_IDLE: m_mode = M_REC;
        M_REC: if (td) begin
          if (m_phase == PH - 1) begin
            m_q.push_back(rw);
            m_phase = 0;
            if (m_q.size() == N) m_mode = M_DONE;
          end else m_phase++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model();
    chk("rnd_trials", trials_rec, m_q.size());
    chk("rnd_total", total_correct, sum_last(N));
    chk("rnd_win", win_count, sum_last(W));
    chk("rnd_crit", criterion_met, m_crit);
    chk("rnd_crit_trial", crit_trial, m_crit_t);
    chk("rnd_full", full, (m_q.size() == N) ? 1 : 0);
  endtask

  typedef struct {
    bit r; bit td; bit rw;
    int e_trials; int e_total; int e_win;
  } vec_t;
  vec_t tv[10];

  initial begin
    int n, done_cyc, aborts;
    bit held, crit_seen;
    int held_val;

    tv[0] = '{1,1,1, 0,0,0};
    tv[1] = '{1,1,0, 1,0,0};
    tv[2] = '{1,0,1, 1,0,0};
    tv[3] = '{1,1,0, 1,0,0};
    tv[4] = '{1,1,1, 2,1,1};
    tv[5] = '{1,1,0, 2,1,1};
    tv[6] = '{1,1,1, 3,2,2};
    tv[7] = '{1,0,0, 3,2,2};
    tv[8] = '{1,1,1, 3,2,2};
    tv[9] = '{0,1,1, 0,0,0};

    // Reset state
    #12;
    chk("rst_trials", trials_rec, 0);
    chk("rst_total", total_correct, 0);
    chk("rst_win", win_count, 0);
    chk("rst_crit", criterion_met, 0);
    chk("rst_crit_trial", crit_trial, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Phase sampling table; last row drops run together with a pulse
    cycle(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(tv[i].r, tv[i].td, tv[i].rw);
      chk($sformatf("tbl%0d_trials", i), trials_rec, tv[i].e_trials);
      chk($sformatf("tbl%0d_total", i), total_correct, tv[i].e_total);
      chk($sformatf("tbl%0d_win", i), win_count, tv[i].e_win);
    end

    // All-reward run
`ifdef SCORE_BLOCK_AVG_EN
    blk_pulses = 0;
`endif
    cycle(1, 0, 0);
    for (int i = 0; i < 2 * N; i++) cycle(1, 1, 1);
    chk("all_trials", trials_rec, N);
    chk("all_total", total_correct, N);
    chk("all_win", win_count, W);
    chk("all_crit", criterion_met, 1);
    chk("all_crit_trial", crit_trial, CR);
    chk("all_full", full, 1);
`ifdef SCORE_BLOCK_AVG_EN
    chk("blk_pulses", blk_pulses, N / W);
    chk("blk_last", blk_last, W);
`endif
    for (int i = 0; i < 6; i++) cycle(1, 1, i % 2);
    chk("done_trials", trials_rec, N);
    chk("done_total", total_correct, N);
    chk("done_win", win_count, W);
    chk("done_full", full, 1);

    // Alternating rewarded trials
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    crit_seen = 0;
    for (int t = 0; t < N; t++) begin
      cycle(1, 1, 1);
      crit_seen |= criterion_met;
      cycle(1, 1, (t % 2 == 0));
      crit_seen |= criterion_met;
    end
    chk("alt_trials", trials_rec, N);
    chk("alt_total", total_correct, N / 2);
    chk("alt_win", win_count, 5);
    chk("alt_crit_seen", crit_seen, 0);

    // Random stimulus against the reference model, with occasional aborts
    cycle(0, 0, 0);
    model_reset();
    done_cyc = 0; aborts = 0;
    for (int c = 0; c < 6000 && done_cyc < 10; c++) begin
      bit r, td, rw;
      r = 1;
      if (aborts < 2 && $urandom_range(0, 399) == 0) begin r = 0; aborts++; end
      td = $urandom_range(0, 1);
      rw = $urandom_range(0, 1);
      cycle(r, td, rw);
      model_step(r, td, rw);
      check_model();
      if (m_mode == M_DONE) done_cyc++;
    end
    chk("rnd_reached_done", done_cyc, 10);

    // Dump with out_ready pattern 1,0,0,1
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    n = 0; held = 0; held_val = 0;
    for (int k = 0; k < 1000 && n < N; k++) begin
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      chk("dump_valid", out_valid, 1);
      if (held) chk("dump_hold", {out_data, out_last}, held_val);
      if (out_ready) begin
        chk($sformatf("dump_data%0d", n), out_data, (n < m_q.size()) ? m_q[n] : 0);
        chk($sformatf("dump_last%0d", n), out_last, (n == N - 1) ? 1 : 0);
        n++;
        held = 0;
      end else begin
        held = 1;
        held_val = {out_data, out_last};
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("dump_count", n, N);
    chk("dump_end_valid", out_valid, 0);

    // Repeat dump aborted by run=0 at ptr=37
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 37; k++) begin @(posedge clk); #1; end
    chk("abort_pre_valid", out_valid, 1);
    chk("abort_data37", out_data, (m_q.size() > 37) ? m_q[37] : 0);
    run = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 0);
    cycle(1, 0, 0);
    chk("restart_trials", trials_rec, 0);
    chk("restart_crit", criterion_met, 0);
    chk("restart_full", full, 0);

    // Async reset mid-RECORD
    for (int i = 0; i < 10; i++) cycle(1, 1, 1);
    chk("pre_arst_trials", trials_rec, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_trials", trials_rec, 0);
    chk("arst_total", total_correct, 0);
    chk("arst_win", win_count, 0);
    chk("arst_crit", criterion_met, 0);
    chk("arst_full", full, 0);
    chk("arst_valid", out_valid, 0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
